// File: rtl/uart_rx_cfg_if.sv
// Serial line in, received word and status out, between the pad and the byte consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Busy;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver with compile-time data width, parity and stop bits, plus
// parity/framing error and line-break detection with break lockout.
//
//   state   | meaning
//   IDLE    | line idle, waiting for a low on rx_s
//   START   | qualifying the start bit at mid-bit
//   DATA    | shifting in data bits, LSB first
//   PARITY  | sampling and checking the parity bit
//   STOP    | sampling stop bits, latching framing error
//   DONE    | one cycle: publish word and flags, pulse o_Rx_DV
//   WAIT_HI | line held low after a bad frame; wait for idle high
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  uart_rx_cfg_if.slave   bus
);

  localparam int              CNT_W         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MID      = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_TC       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam bit              PAR_EN        = (PARITY_EN != 0);
  localparam bit              PAR_ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_DONE    = 3'd5,
    S_WAIT_HI = 3'd6
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CNT_W-1:0]     count;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_err;
  logic                 frm_err;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  assign bus.o_Busy = (state != S_IDLE);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state            <= S_IDLE;
      count            <= '0;
      idx              <= '0;
      shreg            <= '0;
      par_bit          <= 1'b0;
      par_err          <= 1'b0;
      frm_err          <= 1'b0;
      bus.o_Rx_DV      <= 1'b0;
      bus.o_Rx_Byte    <= '0;
      bus.o_Parity_Err <= 1'b0;
      bus.o_Frame_Err  <= 1'b0;
      bus.o_Break      <= 1'b0;
    end else begin
      bus.o_Rx_DV <= 1'b0;
      case (state)
        S_IDLE: begin
          count   <= '0;
          idx     <= '0;
          par_bit <= 1'b0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (count == CNT_MID) begin
            count <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DATA: begin
          if (count == CNT_TC) begin
            count <= '0;
            // Right shift with insertion at MSB leaves the LSB-first word aligned
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_DATA_LAST) begin
              idx   <= '0;
              state <= PAR_EN ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        S_PARITY: begin
          if (count == CNT_TC) begin
            count   <= '0;
            par_bit <= rx_s;
            par_err <= ((^shreg) ^ rx_s) != PAR_ODD;
            state   <= S_STOP;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_STOP: begin
          if (count == CNT_TC) begin
            count <= '0;
            if (!rx_s) frm_err <= 1'b1;
            if (idx == IDX_STOP_LAST) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          count            <= '0;
          idx              <= '0;
          bus.o_Rx_DV      <= 1'b1;
          bus.o_Rx_Byte    <= shreg;
          bus.o_Parity_Err <= PAR_EN && par_err;
          bus.o_Frame_Err  <= frm_err;
          bus.o_Break      <= frm_err && (shreg == '0) && (!PAR_EN || !par_bit);
          // A low line after a framing error is a break: hold off until it idles
          state            <= (rx_s || !frm_err) ? S_IDLE : S_WAIT_HI;
        end
        S_WAIT_HI: begin
          count <= '0;
          idx   <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          count <= '0;
          idx   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
